shift_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for MIPS shift ops (SLL/SRL/SRA, fixed or variable amount).

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_step.sv | 23 ++
 rtl/shift_seq_ctrl.sv | 112 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared constants and encodings for the multi-cycle shift sequencer.
// Optional build macro used by this slice: SHIFT_FAST4_EN (4-position steps).
package shift_seq_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One shift step: moves d by 1 position, or by 4 when by4 is set.
// by4 is tied low by the parent unless SHIFT_FAST4_EN is defined.
module shift_step
  import shift_seq_pkg::*;
(
  input  op_e           op,
  input  logic [DW-1:0] d,
  input  logic          by4,
  output logic [DW-1:0] q
);

  // Shift direction and fill selected by op; reserved op passes data through
  always_comb begin
    q = d;
    case (op)
      OP_SLL:  q = by4 ? {d[DW-5:0], 4'b0000} : {d[DW-2:0], 1'b0};
      OP_SRL:  q = by4 ? {4'b0000, d[DW-1:4]} : {1'b0, d[DW-1:1]};
      OP_SRA:  q = by4 ? {{4{d[DW-1]}}, d[DW-1:4]} : {d[DW-1], d[DW-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer with start/busy/done handshake for EX stage.
// Define SHIFT_FAST4_EN to step 4 positions per cycle while the count is >= 4.
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic           variable,
  input  logic [SAW-1:0] shamt,
  input  logic [DW-1:0]  rs_val,
  input  logic [DW-1:0]  rt_val,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  result
);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [SAW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  result_q, result_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [SAW-1:0] amt_c;
  logic           by4_c;
  logic [DW-1:0]  step_c;
  logic           rs_hi_unused;

  // Only the low shift-amount bits of rs take part
  assign rs_hi_unused = ^rs_val[DW-1:SAW];
  assign amt_c        = variable ? rs_val[SAW-1:0] : shamt;

`ifdef SHIFT_FAST4_EN
  assign by4_c = (cnt_q >= SAW'(4));
`else
  assign by4_c = 1'b0;
`endif

  shift_step u_step (
    .op  (op_q),
    .d   (data_q),
    .by4 (by4_c),
    .q   (step_c)
  );

  // Next-state, counter, data and result update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_e'(op);
          cnt_d  = amt_c;
          data_d = rt_val;
          if ((amt_c == '0) || (op_e'(op) == OP_RSV)) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            result_d = rt_val;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_c;
        cnt_d  = cnt_q - (by4_c ? SAW'(4) : SAW'(1));
        // Last step lands the result together with the done pulse
        if (cnt_d == '0) begin
          state_d  = ST_DONE;
          result_d = step_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers, asynchronous reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized ops
// against a schedule/golden model. Build with or without SHIFT_FAST4_EN.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        variable = 1'b0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  shift_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .variable (variable),
    .shamt    (shamt),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  // Model: op presented in cycle m_s finishes m_lat cycles later
  bit          m_active = 1'b0;
  int          m_s = 0;
  int          m_lat = 0;
  int          m_free = 0;
  int          m_ops = 0;
  logic [31:0] m_new = 32'd0;
  logic [31:0] m_prev = 32'd0;

  logic        exp_busy, exp_done;
  logic [31:0] exp_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o, input int n);
    if (o == 2'b11 || n == 0) return 1;
`ifdef SHIFT_FAST4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  function automatic logic [31:0] golden(input logic [1:0] o, input int n, input logic [31:0] rt);
    case (o)
      2'b00:   return rt << n;
      2'b01:   return rt >> n;
      2'b10:   return $unsigned($signed(rt) >>> n);
      default: return rt;
    endcase
  endfunction

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      exp_busy = m_active && (cyc > m_s) && (cyc < m_s + m_lat);
      exp_done = m_active && (cyc == m_s + m_lat);
      exp_res  = (m_active && (cyc >= m_s + m_lat)) ? m_new : m_prev;
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("result", result, exp_res);
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic drive(input logic st, input logic [1:0] o, input logic v,
                       input logic [4:0] sa, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    start = st; op = o; variable = v; shamt = sa; rs_val = rs; rt_val = rt;
    if (st && !rst && cyc >= m_free) begin
      n        = v ? int'(rs[4:0]) : int'(sa);
      m_prev   = m_active ? m_new : m_prev;
      m_s      = cyc;
      m_lat    = lat_of(o, n);
      m_new    = golden(o, n, rt);
      m_active = 1'b1;
      m_free   = cyc + m_lat + 1;
      m_ops++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; m_active = 1'b0; m_prev = 32'd0;
  endtask

  task automatic release_reset();
    rst = 1'b0; m_free = cyc;
  endtask

  task automatic run_dir(input string nm, input logic [1:0] o, input logic v, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp_r,
                         input int exp_lat, input bit exp_b, input bit hold);
    int s, d1;
    bit got, seen_b;
    drive(1'b0, o, v, sa, rs, rt);
    for (int i = 0; i < 80 && cyc < m_free; i++) begin
      step();
      drive(1'b0, o, v, sa, rs, rt);
    end
    drive(1'b1, o, v, sa, rs, rt);
    s = cyc; d1 = 0; got = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      drive(hold, o, v, sa, rs, rt);
      if (busy) seen_b = 1'b1;
      if (done) begin got = 1'b1; d1 = cyc; end
    end
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({nm, "_latency"}, 32'(d1 - s), 32'(exp_lat));
      check({nm, "_result"}, result, exp_r);
      check({nm, "_busy_seen"}, 32'(seen_b), 32'(exp_b));
      if (hold) begin
        step();
        drive(1'b1, o, v, sa, rs, rt);
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
        step();
        drive(1'b0, o, v, sa, rs, rt);
        check({nm, "_reaccept_busy"}, 32'(busy), 32'd1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int target, done_hits;
    logic [1:0]  ro;
    logic        rv, rs_t;
    logic [4:0]  rsa, ramt;
    logic [31:0] rrs, rrt;
    int          pick;

    #1;
    do_reset();
    check_en = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    step();
    release_reset();
    drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);

`ifdef SHIFT_FAST4_EN
    run_dir("t2_sll4",  2'b00, 1'b0, 5'd4, 32'd0, 32'h0000_00F1, 32'h0000_0F10, 2, 1'b1, 1'b0);
    run_dir("t3_sra31", 2'b10, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 11, 1'b1, 1'b0);
`else
    run_dir("t2_sll4",  2'b00, 1'b0, 5'd4, 32'd0, 32'h0000_00F1, 32'h0000_0F10, 5, 1'b1, 1'b0);
    run_dir("t3_sra31", 2'b10, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b1, 1'b0);
`endif
    run_dir("t4_srl0",  2'b01, 1'b0, 5'd0, 32'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    run_dir("t5_hold",  2'b01, 1'b0, 5'd3, 32'd0, 32'h8000_0000, 32'h1000_0000, 4, 1'b1, 1'b1);
    run_dir("t6_rsv",   2'b11, 1'b0, 5'd9, 32'd0, 32'h1234_5678, 32'h1234_5678, 1, 1'b0, 1'b0);

    // Abort a long SLL mid-shift with reset
    run_dir("t1_pre",   2'b00, 1'b0, 5'd1, 32'd0, 32'h0000_0001, 32'h0000_0002, 2, 1'b1, 1'b0);
    for (int i = 0; i < 4 && cyc < m_free; i++) begin
      step();
      drive(1'b0, 2'b00, 1'b0, 5'd20, 32'd0, 32'h0000_0003);
    end
    drive(1'b1, 2'b00, 1'b0, 5'd20, 32'd0, 32'h0000_0003);
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b0, 2'b00, 1'b0, 5'd20, 32'd0, 32'h0000_0003);
    end
    check("t1_busy_before_rst", 32'(busy), 32'd1);
    do_reset();
    step();
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_result", result, 32'd0);
    release_reset();
    drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
    done_hits = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
      if (done) done_hits++;
    end
    check("t1_no_done_after_rst", 32'(done_hits), 32'd0);

    // Randomized traffic; start is often held to exercise ignore rules
    target = m_ops + 1500;
    for (int c = 0; c < 70000 && m_ops < target; c++) begin
      step();
      if (rst) release_reset();
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        ro   = 2'($urandom_range(0, 3));
        rv   = 1'($urandom_range(0, 1));
        rsa  = 5'($urandom);
        rrs  = $urandom;
        pick = int'($urandom_range(0, 9));
        ramt = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd31 : (pick == 2) ? 5'd4 : 5'($urandom);
        if (rv) rrs[4:0] = ramt; else rsa = ramt;
        rrt  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
        rs_t = ($urandom_range(0, 3) != 0);
        drive(rs_t, ro, rv, rsa, rrs, rrt);
      end
    end
    check("random_ops_completed", 32'(m_ops >= target), 32'd1);

    if (rst) begin
      step();
      release_reset();
    end
    for (int i = 0; i < 40; i++) begin
      step();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
    end
    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
